// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - fetch vs load/store arbiter for the shared data memory port
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data wins.
package memory_port_arbiter_pkg;
   typedef enum logic [1:0] {
      write_byte = 2'd0,
      write_half = 2'd1,
      write_word = 2'd2
   } write_width_t;
endpackage

module memory_port_arbiter
   import memory_port_arbiter_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ifetch_req_valid,
   input  logic [XLEN-1:0]    ifetch_req_addr,
   output logic               ifetch_req_ready,
   output logic               ifetch_resp_valid,
   output logic [XLEN-1:0]    ifetch_resp_data,
   input  logic               data_req_valid,
   input  logic [XLEN-1:0]    data_req_addr,
   input  logic               data_req_w_enable,
   input  logic [XLEN-1:0]    data_req_w_data,
   input  write_width_t       data_req_w_width,
   output logic               data_req_ready,
   output logic               data_resp_valid,
   output logic [XLEN-1:0]    data_resp_data,
   output logic [XLEN-1:0]    mem_addr,
   output logic [XLEN-1:0]    mem_w_data,
   output write_width_t       mem_w_width,
   output logic               mem_w_enable,
   input  logic [XLEN-1:0]    mem_r_data,
   input  logic               mem_write_complete
);

   typedef enum logic {ISSUE, WRITE_HOLD} state_t;
   typedef enum logic [1:0] {RESP_NONE, RESP_FETCH, RESP_LOAD, RESP_STORE} resp_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t           state_q, state_d;
   resp_t            resp_q, resp_d;
   logic [3:0]       starve_q, starve_d;
   logic [XLEN-1:0]  wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]  wr_data_q, wr_data_d;
   write_width_t     wr_width_q, wr_width_d;
   logic             grant_fetch, grant_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ISSUE;
         resp_q     <= RESP_NONE;
         starve_q   <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_width_q <= write_word;
      end else begin
         state_q    <= state_d;
         resp_q     <= resp_d;
         starve_q   <= starve_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_width_q <= wr_width_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      resp_d            = RESP_NONE;
      starve_d          = starve_q;
      wr_addr_d         = wr_addr_q;
      wr_data_d         = wr_data_q;
      wr_width_d        = wr_width_q;
      grant_fetch       = 1'b0;
      grant_data        = 1'b0;
      ifetch_req_ready  = 1'b0;
      data_req_ready    = 1'b0;
      mem_addr          = '0;
      mem_w_data        = '0;
      mem_w_width       = write_word;
      mem_w_enable      = 1'b0;

      case (state_q)
         ISSUE: begin
            if (ifetch_req_valid && (!data_req_valid || starve_q == LIMIT)) begin
               grant_fetch = 1'b1;
            end else if (data_req_valid) begin
               grant_data = 1'b1;
            end

            if (grant_fetch) begin
               ifetch_req_ready = 1'b1;
               mem_addr         = ifetch_req_addr;
               resp_d           = RESP_FETCH;
            end else if (grant_data) begin
               data_req_ready = 1'b1;
               mem_addr       = data_req_addr;
               if (data_req_w_enable) begin
                  mem_w_enable = 1'b1;
                  mem_w_data   = data_req_w_data;
                  mem_w_width  = data_req_w_width;
                  wr_addr_d    = data_req_addr;
                  wr_data_d    = data_req_w_data;
                  wr_width_d   = data_req_w_width;
                  if (mem_write_complete) begin
                     resp_d = RESP_STORE;
                  end else begin
                     state_d = WRITE_HOLD;
                  end
               end else begin
                  resp_d = RESP_LOAD;
               end
            end
         end
         WRITE_HOLD: begin
            mem_addr     = wr_addr_q;
            mem_w_data   = wr_data_q;
            mem_w_width  = wr_width_q;
            mem_w_enable = 1'b1;
            if (mem_write_complete) begin
               state_d = ISSUE;
               resp_d  = RESP_STORE;
            end
         end
         default: state_d = ISSUE;
      endcase

      if (!ifetch_req_valid || grant_fetch) begin
         starve_d = '0;
      end else if (grant_data && starve_q != LIMIT) begin
         starve_d = starve_q + 4'd1;
      end

      ifetch_resp_valid = (resp_q == RESP_FETCH);
      ifetch_resp_data  = (resp_q == RESP_FETCH) ? mem_r_data : '0;
      data_resp_valid   = (resp_q == RESP_LOAD) || (resp_q == RESP_STORE);
      data_resp_data    = (resp_q == RESP_LOAD) ? mem_r_data : '0;

      // While reset is held every output shows its reset value, so an abandoned access never leaks out.
      if (reset) begin
         ifetch_req_ready  = 1'b0;
         data_req_ready    = 1'b0;
         ifetch_resp_valid = 1'b0;
         ifetch_resp_data  = '0;
         data_resp_valid   = 1'b0;
         data_resp_data    = '0;
         mem_addr          = '0;
         mem_w_data        = '0;
         mem_w_width       = write_word;
         mem_w_enable      = 1'b0;
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed vector bench for memory_port_arbiter
// Includes a 1-cycle-latency word memory model; inputs change at posedge+1, outputs sampled at negedge.
module tb_memory_port_arbiter;
   import memory_port_arbiter_pkg::*;

   logic               clock = 1'b0;
   logic               reset;
   logic               ifetch_req_valid;
   logic [31:0]        ifetch_req_addr;
   logic               ifetch_req_ready;
   logic               ifetch_resp_valid;
   logic [31:0]        ifetch_resp_data;
   logic               data_req_valid;
   logic [31:0]        data_req_addr;
   logic               data_req_w_enable;
   logic [31:0]        data_req_w_data;
   write_width_t       data_req_w_width;
   logic               data_req_ready;
   logic               data_resp_valid;
   logic [31:0]        data_resp_data;
   logic [31:0]        mem_addr;
   logic [31:0]        mem_w_data;
   write_width_t       mem_w_width;
   logic               mem_w_enable;
   logic [31:0]        mem_r_data;
   logic               mem_write_complete;

   int errors = 0;
   int checks = 0;

   memory_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
      .clock              (clock),
      .reset              (reset),
      .ifetch_req_valid   (ifetch_req_valid),
      .ifetch_req_addr    (ifetch_req_addr),
      .ifetch_req_ready   (ifetch_req_ready),
      .ifetch_resp_valid  (ifetch_resp_valid),
      .ifetch_resp_data   (ifetch_resp_data),
      .data_req_valid     (data_req_valid),
      .data_req_addr      (data_req_addr),
      .data_req_w_enable  (data_req_w_enable),
      .data_req_w_data    (data_req_w_data),
      .data_req_w_width   (data_req_w_width),
      .data_req_ready     (data_req_ready),
      .data_resp_valid    (data_resp_valid),
      .data_resp_data     (data_resp_data),
      .mem_addr           (mem_addr),
      .mem_w_data         (mem_w_data),
      .mem_w_width        (mem_w_width),
      .mem_w_enable       (mem_w_enable),
      .mem_r_data         (mem_r_data),
      .mem_write_complete (mem_write_complete)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [64];
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | (i * 4);
      mem_r_data = '0;
   end
   always @(posedge clock) begin
      if (mem_w_enable && mem_write_complete) mem[mem_addr[7:2]] <= mem_w_data;
      mem_r_data <= mem[mem_addr[7:2]];
   end

   typedef struct {
      logic        ifv;
      logic [31:0] ifa;
      logic        dv;
      logic [31:0] da;
      logic        dwe;
      logic [31:0] dwd;
      logic        wc;
      logic        e_ifr;
      logic        e_dr;
      logic [31:0] e_addr;
      logic        e_we;
      logic [31:0] e_wd;
      logic        e_ifrv;
      logic [31:0] e_ifrd;
      logic        e_drv;
      logic [31:0] e_drd;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   function automatic vec_t mk(logic ifv, logic [31:0] ifa, logic dv, logic [31:0] da, logic dwe,
                               logic [31:0] dwd, logic wc, logic e_ifr, logic e_dr, logic [31:0] e_addr,
                               logic e_we, logic [31:0] e_wd, logic e_ifrv, logic [31:0] e_ifrd,
                               logic e_drv, logic [31:0] e_drd);
      vec_t v;
      v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.da = da; v.dwe = dwe; v.dwd = dwd; v.wc = wc;
      v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_addr = e_addr; v.e_we = e_we; v.e_wd = e_wd;
      v.e_ifrv = e_ifrv; v.e_ifrd = e_ifrd; v.e_drv = e_drv; v.e_drd = e_drd;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      ifetch_req_valid   = v.ifv;
      ifetch_req_addr    = v.ifa;
      data_req_valid     = v.dv;
      data_req_addr      = v.da;
      data_req_w_enable  = v.dwe;
      data_req_w_data    = v.dwd;
      data_req_w_width   = write_word;
      mem_write_complete = v.wc;
   endtask

   task automatic check_row(int n, vec_t v);
      chk($sformatf("row%0d ifetch_ready", n), ifetch_req_ready, v.e_ifr);
      chk($sformatf("row%0d data_ready", n), data_req_ready, v.e_dr);
      chk($sformatf("row%0d mem_addr", n), mem_addr, v.e_addr);
      chk($sformatf("row%0d mem_w_enable", n), mem_w_enable, v.e_we);
      chk($sformatf("row%0d mem_w_data", n), mem_w_data, v.e_wd);
      chk($sformatf("row%0d ifetch_resp_valid", n), ifetch_resp_valid, v.e_ifrv);
      chk($sformatf("row%0d ifetch_resp_data", n), ifetch_resp_data, v.e_ifrd);
      chk($sformatf("row%0d data_resp_valid", n), data_resp_valid, v.e_drv);
      chk($sformatf("row%0d data_resp_data", n), data_resp_data, v.e_drd);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      //           ifv ifa           dv da            we dwd           wc  ifr dr addr         we wd            ifrv ifrd          drv drd
      vecs[0]  = mk(0, 32'h0,       0, 32'h0,       0, 32'h0,       1,  0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h0);
      vecs[1]  = mk(1, 32'h20000,   0, 32'h0,       0, 32'h0,       1,  1, 0, 32'h20000,   0, 32'h0,       0, 32'h0,        0, 32'h0);
      vecs[2]  = mk(1, 32'h20004,   0, 32'h0,       0, 32'h0,       1,  1, 0, 32'h20004,   0, 32'h0,       1, 32'hC0DE0000, 0, 32'h0);
      vecs[3]  = mk(0, 32'h0,       0, 32'h0,       0, 32'h0,       1,  0, 0, 32'h0,       0, 32'h0,       1, 32'hC0DE0004, 0, 32'h0);
      vecs[4]  = mk(0, 32'h0,       1, 32'h20010,   1, 32'hDEADBEEF,1,  0, 1, 32'h20010,   1, 32'hDEADBEEF,0, 32'h0,        0, 32'h0);
      vecs[5]  = mk(0, 32'h0,       1, 32'h20010,   0, 32'h0,       1,  0, 1, 32'h20010,   0, 32'h0,       0, 32'h0,        1, 32'h0);
      vecs[6]  = mk(0, 32'h0,       0, 32'h0,       0, 32'h0,       1,  0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        1, 32'hDEADBEEF);
      vecs[7]  = mk(1, 32'h20020,   1, 32'h20030,   0, 32'h0,       1,  0, 1, 32'h20030,   0, 32'h0,       0, 32'h0,        0, 32'h0);
      vecs[8]  = mk(1, 32'h20020,   1, 32'h20034,   0, 32'h0,       1,  0, 1, 32'h20034,   0, 32'h0,       0, 32'h0,        1, 32'hC0DE0030);
      vecs[9]  = mk(1, 32'h20020,   1, 32'h20038,   0, 32'h0,       1,  0, 1, 32'h20038,   0, 32'h0,       0, 32'h0,        1, 32'hC0DE0034);
      vecs[10] = mk(1, 32'h20020,   1, 32'h2003C,   0, 32'h0,       1,  0, 1, 32'h2003C,   0, 32'h0,       0, 32'h0,        1, 32'hC0DE0038);
      vecs[11] = mk(1, 32'h20020,   1, 32'h20040,   0, 32'h0,       1,  1, 0, 32'h20020,   0, 32'h0,       0, 32'h0,        1, 32'hC0DE003C);
      vecs[12] = mk(1, 32'h20024,   1, 32'h20040,   0, 32'h0,       1,  0, 1, 32'h20040,   0, 32'h0,       1, 32'hC0DE0020, 0, 32'h0);
      vecs[13] = mk(0, 32'h0,       0, 32'h0,       0, 32'h0,       1,  0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        1, 32'hC0DE0040);
      for (int i = 14; i < 18; i++)
         vecs[i] = mk(0, 32'h0,     0, 32'h0,       0, 32'h0,       1,  0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h0);
      vecs[18] = mk(1, 32'h20000,   1, 32'h20008,   0, 32'h0,       1,  0, 1, 32'h20008,   0, 32'h0,       0, 32'h0,        0, 32'h0);

      drive(vecs[0]);
      ifetch_req_valid = 1'b1;
      reset = 1'b1;
      next_cycle();
      @(negedge clock);
      chk("reset ifetch_ready", ifetch_req_ready, 0);
      chk("reset data_ready", data_req_ready, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_w_enable", mem_w_enable, 0);
      chk("reset mem_w_width", mem_w_width, write_word);
      chk("reset ifetch_resp_valid", ifetch_resp_valid, 0);
      chk("reset data_resp_valid", data_resp_valid, 0);
      next_cycle();
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(negedge clock);
         check_row(i, vecs[i]);
         next_cycle();
      end

      drive(vecs[0]);
      repeat (2) next_cycle();

      // Slow MMIO store: complete held low three cycles while fetch waits.
      ifetch_req_valid   = 1'b1;
      ifetch_req_addr    = 32'h20060;
      data_req_valid     = 1'b1;
      data_req_addr      = 32'h20050;
      data_req_w_enable  = 1'b1;
      data_req_w_data    = 32'h12345678;
      data_req_w_width   = write_word;
      mem_write_complete = 1'b0;
      @(negedge clock);
      chk("slow c0 data_ready", data_req_ready, 1);
      chk("slow c0 ifetch_ready", ifetch_req_ready, 0);
      chk("slow c0 mem_w_enable", mem_w_enable, 1);
      chk("slow c0 mem_addr", mem_addr, 32'h20050);
      next_cycle();
      data_req_valid = 1'b0;
      data_req_w_data = 32'h0;
      data_req_addr = 32'h0;
      for (int c = 1; c < 4; c++) begin
         mem_write_complete = (c == 3);
         @(negedge clock);
         chk($sformatf("slow c%0d mem_w_enable", c), mem_w_enable, 1);
         chk($sformatf("slow c%0d mem_addr", c), mem_addr, 32'h20050);
         chk($sformatf("slow c%0d mem_w_data", c), mem_w_data, 32'h12345678);
         chk($sformatf("slow c%0d mem_w_width", c), mem_w_width, write_word);
         chk($sformatf("slow c%0d ifetch_ready", c), ifetch_req_ready, 0);
         chk($sformatf("slow c%0d data_ready", c), data_req_ready, 0);
         chk($sformatf("slow c%0d data_resp_valid", c), data_resp_valid, 0);
         next_cycle();
      end
      mem_write_complete = 1'b0;
      @(negedge clock);
      chk("slow c4 data_resp_valid", data_resp_valid, 1);
      chk("slow c4 data_resp_data", data_resp_data, 0);
      chk("slow c4 ifetch_ready", ifetch_req_ready, 1);
      chk("slow c4 mem_addr", mem_addr, 32'h20060);
      chk("slow c4 mem_w_enable", mem_w_enable, 0);
      next_cycle();
      ifetch_req_valid = 1'b0;
      @(negedge clock);
      chk("slow c5 ifetch_resp_valid", ifetch_resp_valid, 1);
      chk("slow c5 ifetch_resp_data", ifetch_resp_data, 32'hC0DE0060);
      chk("slow c5 data_resp_valid", data_resp_valid, 0);
      next_cycle();

      // Reset while holding a write.
      data_req_valid     = 1'b1;
      data_req_addr      = 32'h20070;
      data_req_w_enable  = 1'b1;
      data_req_w_data    = 32'hCAFEF00D;
      mem_write_complete = 1'b0;
      @(negedge clock);
      chk("rsthold c0 mem_w_enable", mem_w_enable, 1);
      next_cycle();
      data_req_valid = 1'b0;
      @(negedge clock);
      chk("rsthold c1 mem_w_enable", mem_w_enable, 1);
      next_cycle();
      reset = 1'b1;
      @(negedge clock);
      chk("rsthold c2 mem_w_enable", mem_w_enable, 0);
      chk("rsthold c2 mem_addr", mem_addr, 0);
      chk("rsthold c2 data_resp_valid", data_resp_valid, 0);
      next_cycle();
      reset = 1'b0;
      ifetch_req_valid = 1'b1;
      ifetch_req_addr  = 32'h20004;
      @(negedge clock);
      chk("rsthold c3 mem_w_enable", mem_w_enable, 0);
      chk("rsthold c3 data_resp_valid", data_resp_valid, 0);
      chk("rsthold c3 ifetch_ready", ifetch_req_ready, 1);
      chk("rsthold c3 mem_addr", mem_addr, 32'h20004);
      next_cycle();
      ifetch_req_valid = 1'b0;
      @(negedge clock);
      chk("rsthold c4 ifetch_resp_valid", ifetch_resp_valid, 1);
      chk("rsthold c4 ifetch_resp_data", ifetch_resp_data, 32'hC0DE0004);
      chk("rsthold c4 data_resp_valid", data_resp_valid, 0);
      next_cycle();

      // Reset with a read in flight.
      ifetch_req_valid = 1'b1;
      ifetch_req_addr  = 32'h20008;
      @(negedge clock);
      chk("rstrd c0 ifetch_ready", ifetch_req_ready, 1);
      next_cycle();
      ifetch_req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      chk("rstrd c1 ifetch_resp_valid", ifetch_resp_valid, 0);
      chk("rstrd c1 ifetch_resp_data", ifetch_resp_data, 0);
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      chk("rstrd c2 ifetch_resp_valid", ifetch_resp_valid, 0);
      chk("rstrd c2 data_resp_valid", data_resp_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
